// File: rtl/fan_pwm_gen_if.sv
// Control and drive signals of the fan PWM generator, grouped so the
// stimulus side (master) and the generator (slave) share one bundle.
interface fan_pwm_gen_if;
    logic       tick_in;
    logic       enable_in;
    logic [7:0] duty_in;
    logic       pwm_out;
    logic       period_start_out;
    logic [1:0] state_out;

    modport master (
        output tick_in, enable_in, duty_in,
        input  pwm_out, period_start_out, state_out
    );

    modport slave (
        input  tick_in, enable_in, duty_in,
        output pwm_out, period_start_out, state_out
    );
endinterface

// File: rtl/fan_pwm_gen.sv
// Fan PWM generator: 255-tick PWM periods, optional full-duty kick after
// enable, stepwise ramp toward the target duty, then direct duty tracking.
module fan_pwm_gen #(
    parameter int KICK_PERIODS = 2,
    parameter int RAMP_STEP    = 16
) (
    input  logic          clk_in,
    input  logic          rst_in,
    fan_pwm_gen_if.slave  fan
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RAMP = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam int           KW        = (KICK_PERIODS < 2) ? 1 : $clog2(KICK_PERIODS + 1);
    localparam logic [KW-1:0] KICK_LAST = KW'((KICK_PERIODS > 0) ? KICK_PERIODS - 1 : 0);
    localparam logic [8:0]   STEP9     = 9'(RAMP_STEP);

    state_t        state;
    logic [7:0]    phase;
    logic [7:0]    cur_duty;
    logic [KW-1:0] kick_cnt;
    logic          tick_d;
    logic          pwm_q;
    logic          period_start_q;

    logic          tick;
    logic          wrap;
    logic [7:0]    phase_nx;
    logic [7:0]    ramp_val;

    // One step toward the target; 9-bit math so neither direction can wrap.
    function automatic logic [7:0] ramp_next(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] up;
        logic [8:0] dn;
        up = {1'b0, cur} + STEP9;
        dn = {1'b0, cur} - STEP9;
        if (cur < tgt)
            return (up > {1'b0, tgt}) ? tgt : up[7:0];
        else if (cur > tgt)
            return (dn[8] || (dn[7:0] < tgt)) ? tgt : dn[7:0];
        else
            return tgt;
    endfunction

    always_comb begin
        tick     = fan.tick_in & ~tick_d;
        wrap     = (phase == 8'd254);
        phase_nx = wrap ? 8'd0 : phase + 8'd1;
        ramp_val = ramp_next(cur_duty, fan.duty_in);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            phase          <= 8'd0;
            cur_duty       <= 8'd0;
            kick_cnt       <= '0;
            tick_d         <= 1'b1;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            tick_d         <= fan.tick_in;
            period_start_q <= 1'b0;
            if (!fan.enable_in) begin
                state    <= IDLE;
                phase    <= 8'd0;
                cur_duty <= 8'd0;
                kick_cnt <= '0;
                pwm_q    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        phase          <= 8'd0;
                        kick_cnt       <= '0;
                        period_start_q <= 1'b1;
                        if (KICK_PERIODS > 0) begin
                            state    <= KICK;
                            cur_duty <= 8'd255;
                            pwm_q    <= 1'b1;
                        end else begin
                            state    <= RAMP;
                            cur_duty <= 8'd0;
                            pwm_q    <= 1'b0;
                        end
                    end
                    default: begin
                        if (tick) begin
                            phase <= phase_nx;
                            if (!wrap) begin
                                pwm_q <= (phase_nx < cur_duty);
                            end else begin
                                // Period boundary: the only place duty may change.
                                period_start_q <= 1'b1;
                                case (state)
                                    KICK: begin
                                        if (kick_cnt == KICK_LAST) begin
                                            kick_cnt <= '0;
                                            cur_duty <= ramp_val;
                                            pwm_q    <= (ramp_val != 8'd0);
                                            state    <= (ramp_val == fan.duty_in) ? RUN : RAMP;
                                        end else begin
                                            kick_cnt <= kick_cnt + 1'b1;
                                            pwm_q    <= (cur_duty != 8'd0);
                                        end
                                    end
                                    RAMP: begin
                                        cur_duty <= ramp_val;
                                        pwm_q    <= (ramp_val != 8'd0);
                                        if (ramp_val == fan.duty_in) state <= RUN;
                                    end
                                    RUN: begin
                                        cur_duty <= fan.duty_in;
                                        pwm_q    <= (fan.duty_in != 8'd0);
                                    end
                                    default: state <= IDLE;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign fan.pwm_out          = pwm_q;
    assign fan.period_start_out = period_start_q;
    assign fan.state_out        = state;
endmodule

// File: tb/tb_fan_pwm_gen.sv
// Bench for fan_pwm_gen: per-period high-time and boundary checks against
// duty sequences derived from the kick/ramp/run rules.
module tb_fan_pwm_gen;
  logic clk;
  logic rst;
  fan_pwm_gen_if bus ();

  fan_pwm_gen #(.KICK_PERIODS(2), .RAMP_STEP(64)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .fan    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int glitch_cnt = 0;
  logic s_pwm;
  logic s_ps;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: one ramp step toward the target in plain integer math.
  function automatic int toward(input int d, input int t);
    if (d < t) return (d + 64 > t) ? t : d + 64;
    if (d > t) return (d - 64 < t) ? t : d - 64;
    return t;
  endfunction

  // Entered at a negedge with tick_in low; samples right after the tick edge.
  task automatic do_tick();
    int extra;
    int low;
    bus.tick_in = 1'b1;
    @(negedge clk);
    s_pwm = bus.pwm_out;
    s_ps  = bus.period_start_out;
    extra = $urandom_range(0, 1);
    low   = $urandom_range(1, 2);
    repeat (extra) begin
      @(negedge clk);
      if (bus.pwm_out !== s_pwm || bus.period_start_out !== 1'b0) glitch_cnt++;
    end
    bus.tick_in = 1'b0;
    repeat (low) begin
      @(negedge clk);
      if (bus.pwm_out !== s_pwm || bus.period_start_out !== 1'b0) glitch_cnt++;
    end
  endtask

  task automatic measure_period(input int change_at, input logic [7:0] new_duty,
                                output int high, output int spurious, output logic bnd);
    high = int'(bus.pwm_out);
    spurious = 0;
    for (int i = 1; i < 255; i++) begin
      if (i == change_at) bus.duty_in = new_duty;
      do_tick();
      high += int'(s_pwm);
      spurious += int'(s_ps);
    end
    do_tick();
    bnd = s_ps;
  endtask

  task automatic do_reset(input logic tick_lvl, input logic en_lvl);
    @(negedge clk);
    rst = 1'b1;
    bus.tick_in = tick_lvl;
    bus.enable_in = en_lvl;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int h, sp;
    logic b;
    do_reset(1'b1, 1'b1);
    n_checks++;
    if (bus.pwm_out !== 1'b0 || bus.period_start_out !== 1'b0 || bus.state_out !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pwm=%0b ps=%0b state=%0d expected 0 0 0",
               bus.pwm_out, bus.period_start_out, bus.state_out);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.state_out !== 2'd1 || bus.period_start_out !== 1'b1 || bus.pwm_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_kick_entry: got state=%0d ps=%0b pwm=%0b expected 1 1 1",
               bus.state_out, bus.period_start_out, bus.pwm_out);
    end
    repeat (3) @(negedge clk);
    bus.tick_in = 1'b0;
    repeat (2) @(negedge clk);
    measure_period(-1, 8'd0, h, sp, b);
    n_checks++;
    if (sp !== 0 || b !== 1'b1 || h !== 255) begin
      n_fail++;
      $display("FAIL reset_no_tick: got high=%0d early_starts=%0d boundary=%0b expected 255 0 1", h, sp, b);
    end
  endtask

  task automatic run_sequence(input string tag, input int exp_h[$], input int exp_s[$]);
    int h, sp;
    logic b;
    for (int p = 0; p < exp_h.size(); p++) begin
      n_checks++;
      if (bus.state_out !== 2'(exp_s[p])) begin
        n_fail++;
        $display("FAIL %s_state[%0d]: got %0d expected %0d", tag, p, bus.state_out, exp_s[p]);
      end
      measure_period(-1, 8'd0, h, sp, b);
      n_checks++;
      if (h !== exp_h[p] || sp !== 0 || b !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_period[%0d]: got high=%0d starts=%0d boundary=%0b expected %0d 0 1",
                 tag, p, h, sp, b, exp_h[p]);
      end
    end
  endtask

  task automatic test_kick_ramp();
    do_reset(1'b0, 1'b0);
    rst = 1'b0;
    bus.duty_in = 8'd100;
    bus.enable_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.state_out !== 2'd1 || bus.period_start_out !== 1'b1 || bus.pwm_out !== 1'b1) begin
      n_fail++;
      $display("FAIL kick_entry: got state=%0d ps=%0b pwm=%0b expected 1 1 1",
               bus.state_out, bus.period_start_out, bus.pwm_out);
    end
    run_sequence("kick_ramp", '{255, 255, 191, 127, 100}, '{1, 1, 2, 2, 3});
  endtask

  task automatic test_run_duty();
    int h, sp;
    logic b;
    logic [7:0] duties [3] = '{8'd128, 8'd0, 8'd255};
    for (int k = 0; k < 3; k++) begin
      bus.duty_in = duties[k];
      measure_period(-1, 8'd0, h, sp, b);
      glitch_cnt = 0;
      measure_period(-1, 8'd0, h, sp, b);
      n_checks++;
      if (h !== int'(duties[k]) || sp !== 0 || b !== 1'b1 || bus.state_out !== 2'd3) begin
        n_fail++;
        $display("FAIL run_duty_%0d: got high=%0d starts=%0d boundary=%0b state=%0d expected %0d 0 1 3",
                 duties[k], h, sp, b, bus.state_out, duties[k]);
      end
      if (duties[k] == 8'd0 || duties[k] == 8'd255) begin
        n_checks++;
        if (glitch_cnt !== 0 || bus.pwm_out !== (duties[k] != 8'd0)) begin
          n_fail++;
          $display("FAIL run_const_%0d: got glitches=%0d pwm_at_wrap=%0b expected 0 %0b",
                   duties[k], glitch_cnt, bus.pwm_out, duties[k] != 8'd0);
        end
      end
    end
  endtask

  task automatic test_midperiod_change();
    int h, sp;
    logic b;
    bus.duty_in = 8'd200;
    measure_period(-1, 8'd0, h, sp, b);
    measure_period(100, 8'd40, h, sp, b);
    n_checks++;
    if (h !== 200 || b !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_change_current: got high=%0d boundary=%0b expected 200 1", h, b);
    end
    measure_period(-1, 8'd0, h, sp, b);
    n_checks++;
    if (h !== 40 || b !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_change_next: got high=%0d boundary=%0b expected 40 1", h, b);
    end
  endtask

  task automatic test_enable_drop();
    int h, sp;
    logic b;
    do_reset(1'b0, 1'b0);
    rst = 1'b0;
    bus.duty_in = 8'd150;
    bus.enable_in = 1'b1;
    @(negedge clk);
    measure_period(-1, 8'd0, h, sp, b);
    repeat (50) do_tick();
    bus.enable_in = 1'b0;
    bus.tick_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.pwm_out !== 1'b0 || bus.state_out !== 2'd0 || bus.period_start_out !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_enable: got pwm=%0b state=%0d ps=%0b expected 0 0 0",
               bus.pwm_out, bus.state_out, bus.period_start_out);
    end
    bus.tick_in = 1'b0;
    @(negedge clk);
    repeat (5) do_tick();
    n_checks++;
    if (bus.pwm_out !== 1'b0 || bus.state_out !== 2'd0) begin
      n_fail++;
      $display("FAIL drop_idle_hold: got pwm=%0b state=%0d expected 0 0", bus.pwm_out, bus.state_out);
    end
    bus.enable_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.state_out !== 2'd1 || bus.period_start_out !== 1'b1 || bus.pwm_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rekick_entry: got state=%0d ps=%0b pwm=%0b expected 1 1 1",
               bus.state_out, bus.period_start_out, bus.pwm_out);
    end
    run_sequence("rekick", '{255, 255}, '{1, 1});
    n_checks++;
    if (bus.state_out !== 2'd2) begin
      n_fail++;
      $display("FAIL rekick_ramp_state: got %0d expected 2", bus.state_out);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int h, sp;
    logic b;
    repeat (30) do_tick();
    do_reset(1'b1, 1'b1);
    n_checks++;
    if (bus.pwm_out !== 1'b0 || bus.period_start_out !== 1'b0 || bus.state_out !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_ramp: got pwm=%0b ps=%0b state=%0d expected 0 0 0",
               bus.pwm_out, bus.period_start_out, bus.state_out);
    end
    rst = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    bus.tick_in = 1'b0;
    repeat (2) @(negedge clk);
    measure_period(-1, 8'd0, h, sp, b);
    n_checks++;
    if (h !== 255 || sp !== 0 || b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ramp_restart: got high=%0d starts=%0d boundary=%0b expected 255 0 1", h, sp, b);
    end
  endtask

  task automatic test_random_ramp();
    for (int it = 0; it < 3; it++) begin
      int tgt;
      int d;
      int exp_h[$];
      int exp_s[$];
      tgt = $urandom_range(0, 255);
      exp_h = '{255, 255};
      exp_s = '{1, 1};
      d = 255;
      do begin
        d = toward(d, tgt);
        exp_h.push_back(d);
        exp_s.push_back((d == tgt) ? 3 : 2);
      end while (d != tgt);
      exp_h.push_back(tgt);
      exp_s.push_back(3);
      do_reset(1'b0, 1'b0);
      rst = 1'b0;
      bus.duty_in = 8'(tgt);
      bus.enable_in = 1'b1;
      @(negedge clk);
      run_sequence($sformatf("rand_%0d", tgt), exp_h, exp_s);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.tick_in = 1'b0;
    bus.enable_in = 1'b0;
    bus.duty_in = 8'd0;
    test_reset();
    test_kick_ramp();
    test_run_duty();
    test_midperiod_change();
    test_enable_drop();
    test_reset_mid_ramp();
    test_random_ramp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fan_pwm_gen.md
FAN_PWM_GEN -- requirements
Module: fan_pwm_gen

Interface
REQ-001 SHALL have parameter KICK_PERIODS, default 2: number of full-duty PWM periods driven after enable; 0 skips the kick phase.
REQ-002 SHALL have parameter RAMP_STEP, default 16: per-period duty change during ramp; legal range 1..255.
REQ-003 SHALL have port clk_in  input  1: the single clock for all logic.
REQ-004 SHALL have port rst_in  input  1: synchronous, active-high reset.
REQ-005 SHALL have port tick_in  input  1: divided clock from the upstream clock divider; a level signal, asynchronous in phase but synchronous to clk_in.
REQ-006 SHALL have port enable_in  input  1: fan enable.
REQ-007 SHALL have port duty_in  input  8: target duty in 1/255 units.
REQ-008 SHALL have port pwm_out  output  1: fan PWM drive, registered.
REQ-009 SHALL have port period_start_out  output  1: one-clk_in pulse at each PWM period start, registered.
REQ-010 SHALL have port state_out  output  2: current state, encoded IDLE=0, KICK=1, RAMP=2, RUN=3.

Function
REQ-011 SHALL detect a tick when tick_in=1 and its registered copy tick_d=0; a tick SHALL be one clk_in cycle long regardless of tick_in high time.
REQ-012 SHALL keep an 8-bit phase counter in IDLE at 0; in other states each tick SHALL advance it by 1, wrapping 254->0 (period = 255 ticks).
REQ-013 SHALL hold an 8-bit cur_duty; pwm_out SHALL be (phase < cur_duty), so 0 is constant low and 255 is constant high.
REQ-014 SHALL update phase, cur_duty, pwm_out, period_start_out and state on the same clk_in edge that samples the tick; there is no extra pipeline stage.
REQ-015 SHALL change cur_duty only at a period boundary (phase wrap to 0) or on state entry, never mid-period.
REQ-016 SHALL pulse period_start_out for one clk_in cycle on each wrap to 0 and on entry to KICK, or to RAMP from IDLE.
REQ-017 IDLE: pwm_out=0, cur_duty=0; when enable_in=1, SHALL go to KICK with cur_duty=255 (KICK_PERIODS>0) or to RAMP with cur_duty=0 (KICK_PERIODS=0), phase=0.
REQ-018 KICK: SHALL count completed periods; at the KICK_PERIODS-th boundary SHALL go to RAMP, applying the first ramp step at that boundary.
REQ-019 RAMP: at each boundary cur_duty SHALL move toward duty_in by RAMP_STEP, clamped to duty_in with no overshoot and no 8-bit wrap (9-bit intermediate).
REQ-020 RAMP: when the updated cur_duty equals duty_in, SHALL go to RUN at that boundary; a duty_in change during RAMP retargets the ramp.
REQ-021 RUN: at each boundary cur_duty SHALL load duty_in directly; duty_in changes mid-period take effect at the next boundary.
REQ-022 SHALL treat enable_in=0 in any state as overriding: next edge goes to IDLE with phase=0, cur_duty=0, pwm_out=0, and kick count cleared.
REQ-023 SHALL give enable_in=0 precedence when it coincides with a tick or a boundary.
REQ-024 SHALL not restart the kick when enable_in stays 1; re-kick only via IDLE.

Reset
REQ-025 On rst_in=1 at a clk_in edge, SHALL set state=IDLE, phase=0, cur_duty=0, kick count=0, pwm_out=0, period_start_out=0.
REQ-026 SHALL reset tick_d to 1, so tick_in held high through reset release produces no tick.
REQ-027 SHALL give rst_in precedence over all other inputs, including mid-period and mid-kick.

Verification
REQ-028 SHALL be verified with KICK_PERIODS=2, RAMP_STEP=64, duty_in=100, enable rising: pwm high for 2x255 ticks; then ramp periods at duty 191, 127, 100; state_out=3 from the boundary where 100 loads.
REQ-029 SHALL be verified in RUN with duty_in=128: each period is 128 ticks high and 127 ticks low, with period_start_out pulsing once per 255 ticks.
REQ-030 SHALL be verified with duty_in=0 and duty_in=255 in RUN: pwm_out constant 0 and constant 1, with no glitch at the wrap.
REQ-031 SHALL be verified by dropping enable_in at phase 50 of a KICK period: next clk_in pwm_out=0, state_out=0, and re-enable re-runs the full kick.
REQ-032 SHALL be verified with duty_in changed 200->40 mid-period in RUN: the current period keeps 200, and the next period is 40.
REQ-033 SHALL be verified with tick_in held high across rst_in release and rst_in asserted mid-RAMP: no tick counted, all outputs 0, state_out=0.
